bootram_bus_bridge: RTL
=======================

BOOTRAM_BUS_BRIDGE -- requirements
Module: bootram_bus_bridge

Interface
REQ-001 Parameter ADDR_W, default 11: byte-address width of the attached single-port x8 boot RAM (2K x 8).
REQ-002 Parameter ENABLE_WRITE, default 1: 0 forces ram_wre low; write requests are still acknowledged.
REQ-003 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port mem_valid  input  1  CPU native-bus request.
REQ-006 Port mem_ready  output  1  one-cycle transfer-complete strobe.
REQ-007 Port mem_addr  input  32  byte address; only [ADDR_W-1:2] used.
REQ-008 Port mem_wdata  input  32  write data, little-endian byte lanes.
REQ-009 Port mem_wstrb  input  4  byte write enables; 4'b0000 means read.
REQ-010 Port mem_rdata  output  32  read data, valid while mem_ready=1.
REQ-011 Port ram_ce, ram_oce, ram_wre, ram_reset  output  1 each  RAM clock enable, output enable, write enable, output-register reset.
REQ-012 Port ram_ad  output  ADDR_W  RAM byte address.
REQ-013 Port ram_din  output  8  RAM write data.
REQ-014 Port ram_dout  input  8  RAM read data, valid the cycle after an enabled read edge (bypass read mode).

Function
REQ-015 FSM states: IDLE, RUN, TAIL, ACK; 2-bit lane counter.
REQ-016 IDLE: on an edge with mem_valid=1, latch mem_addr[ADDR_W-1:2], mem_wdata and mem_wstrb; go to RUN with lane=0. mem_valid is sampled only in IDLE.
REQ-017 RUN, lane k: ram_ce=1, ram_ad={latched word address, k}, ram_din=latched wdata[8k+7:8k], ram_wre=latched wstrb[k] AND ENABLE_WRITE; lane increments each edge; RUN -> TAIL on the edge leaving lane 3.
REQ-018 TAIL: ram_ce=0, ram_wre=0; go to ACK on the next edge.
REQ-019 ACK: mem_ready=1 for exactly one cycle; go to IDLE on the next edge.
REQ-020 Read capture (latched wstrb=0): ram_dout is loaded into mem_rdata[8(k-1)+7:8(k-1)] on the edge leaving RUN lane k (k=1..3); byte 3 is loaded on the edge leaving TAIL.
REQ-021 On writes (any wstrb bit set), mem_rdata holds its previous value; bytes with wstrb[k]=0 are not written.
REQ-022 Latency: mem_valid seen at edge E0 gives mem_ready=1 in the cycle following E5; the next request is accepted no earlier than E7.
REQ-023 RAM control outputs decode combinationally from state, lane and latched registers.
REQ-024 ram_ce, ram_wre and mem_ready are 0 in all states other than those listed above.
REQ-025 ram_oce equals ram_ce; ram_reset equals reset.
REQ-026 Address bits above ADDR_W-1 are ignored; no range checking.
REQ-027 Input changes outside IDLE have no effect on the transfer in progress.

Reset
REQ-028 On reset assertion, immediately (asynchronously): state=IDLE, lane=0, mem_ready=0, ram_ce=0, ram_wre=0, mem_rdata=0, latched address/wdata/wstrb=0.
REQ-029 If reset is asserted mid-transfer, the transfer is aborted with no ack; the first request after deassertion is accepted normally.

Verification
REQ-030 Read: RAM bytes 0x10..0x13 = 06,47,05,08; read mem_addr=0x10 -> mem_ready one cycle at E5+, mem_rdata=0x08054706; ram_ad sequence 0x10,0x11,0x12,0x13.
REQ-031 Full write: mem_addr=0x24, wdata=0xDEADBEEF, wstrb=F; then read 0x24 -> 0xDEADBEEF; ram_wre high on all four RUN cycles.
REQ-032 Partial write: over 0x11223344 at 0x40, write wdata=0xAABBCCDD with wstrb=0101; read back -> 0x11BB33DD; mem_rdata unchanged during the write ack.
REQ-033 ENABLE_WRITE=0: write 0xFFFFFFFF to 0x00 -> acked at the same latency, ram_wre never high; read 0x00 returns the original contents.
REQ-034 Reset during RUN lane 2 of a read -> ram_ce falls with no clock edge, no mem_ready pulse, mem_rdata=0; a following read of 0x10 completes with the correct data.
REQ-035 Address wrap: read mem_addr=0x000007FC with ADDR_W=11 -> ram_ad 0x7FC..0x7FF; mem_addr=0x00000800 -> ram_ad 0x000..0x003.

Source files
------------

// File: rtl/bootram_bus_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : bootram_bus_bridge
// Description : Bridges a 32-bit CPU native bus (valid/ready) onto a single-
//               port x8 boot RAM. Each request is serialised into four byte
//               accesses (lanes 0..3), followed by one tail cycle to collect
//               the last read byte and one acknowledge cycle.
// Ports       : clk, reset       - clock, asynchronous active-high reset
//               mem_valid/ready  - CPU request / one-cycle completion strobe
//               mem_addr         - byte address (bits [ADDR_W-1:2] used)
//               mem_wdata/wstrb  - write data / byte enables (0 = read)
//               mem_rdata        - read data, valid while mem_ready=1
//               ram_ce/oce/wre   - RAM clock, output and write enables
//               ram_reset        - RAM output-register reset (mirrors reset)
//               ram_ad/din/dout  - RAM byte address, write data, read data
// Revision    : 1.0 - initial release
// ============================================================================
module bootram_bus_bridge #(
    parameter int ADDR_W       = 11,
    parameter int ENABLE_WRITE = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_wdata,
    input  logic [3:0]        mem_wstrb,
    output logic [31:0]       mem_rdata,
    output logic              ram_ce,
    output logic              ram_oce,
    output logic              ram_wre,
    output logic              ram_reset,
    output logic [ADDR_W-1:0] ram_ad,
    output logic [7:0]        ram_din,
    input  logic [7:0]        ram_dout
);

    localparam logic c_wr_en = (ENABLE_WRITE != 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_TAIL = 2'd2,
        S_ACK  = 2'd3
    } state_t;

    state_t            r_state;
    logic [1:0]        r_lane;
    logic [ADDR_W-3:0] r_word;
    logic [31:0]       r_wdata;
    logic [3:0]        r_wstrb;
    logic [31:0]       r_rdata;
    logic              r_ready;

    logic              w_is_read;
    logic              w_run;
    logic [1:0]        w_prev_lane;
    logic              w_unused_addr_bits;

    assign w_is_read   = (r_wstrb == 4'b0000);
    assign w_run       = (r_state == S_RUN);
    // RAM output lags the address by one edge, so the byte arriving while
    // in lane k belongs to lane k-1.
    assign w_prev_lane = r_lane - 2'd1;
    assign w_unused_addr_bits = ^{mem_addr[31:ADDR_W], mem_addr[1:0]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_lane  <= 2'd0;
            r_word  <= '0;
            r_wdata <= 32'd0;
            r_wstrb <= 4'd0;
            r_rdata <= 32'd0;
            r_ready <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_ready <= 1'b0;
                    if (mem_valid) begin
                        r_word  <= mem_addr[ADDR_W-1:2];
                        r_wdata <= mem_wdata;
                        r_wstrb <= mem_wstrb;
                        r_lane  <= 2'd0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_lane <= r_lane + 2'd1;
                    if (w_is_read && (r_lane != 2'd0)) begin
                        r_rdata[{w_prev_lane, 3'b000} +: 8] <= ram_dout;
                    end
                    if (r_lane == 2'd3) begin
                        r_state <= S_TAIL;
                    end
                end
                S_TAIL: begin
                    if (w_is_read) begin
                        r_rdata[31:24] <= ram_dout;
                    end
                    r_ready <= 1'b1;
                    r_state <= S_ACK;
                end
                S_ACK: begin
                    r_ready <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_ready <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // RAM controls decode directly from state so an asynchronous reset
    // drops them without waiting for a clock edge.
    assign ram_ce    = w_run;
    assign ram_oce   = w_run;
    assign ram_wre   = w_run & r_wstrb[r_lane] & c_wr_en;
    assign ram_ad    = {r_word, r_lane};
    assign ram_din   = r_wdata[{r_lane, 3'b000} +: 8];
    assign ram_reset = reset;

    assign mem_ready = r_ready;
    assign mem_rdata = r_rdata;

endmodule
`default_nettype wire
